// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the four-register pipeline: hazard stalls, branch flushes,
// memory-wait freeze and a halt/drain sequence, with saturating debug counters.
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned STALL_CNT_W  = 16,
    parameter int unsigned FLUSH_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             id_rn,
    input  logic [3:0]             id_rm,
    input  logic                   id_rn_used,
    input  logic                   id_rm_used,
    input  logic [3:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   branch_taken_ex,
    input  logic                   mem_busy,
    input  logic                   halt_req,
    output logic                   pc_enable,
    output logic                   if_id_enable,
    output logic                   if_id_flush,
    output logic                   id_ex_enable,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_enable,
    output logic                   mem_wb_enable,
    output logic                   mem_wb_bubble,
    output logic [1:0]             state_out,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StHalt    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             drain_cnt_q, drain_cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
    logic                   load_use;

    assign load_use = ex_mem_read &&
                      ((id_rn_used && (id_rn == ex_rd)) || (id_rm_used && (id_rm == ex_rd)));

    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_d       = stall_q;
        flush_d       = flush_q;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d      = StRun;
            drain_cnt_d  = 4'd0;
            stall_d      = '0;
            flush_d      = '0;
        end else begin
            unique case (state_q)
                StRun, StMemWait: begin
                    if (mem_busy) begin
                        // WB retires once while everything upstream holds
                        mem_wb_enable = 1'b1;
                        mem_wb_bubble = 1'b1;
                        state_d       = StMemWait;
                    end else begin
                        pc_enable     = 1'b1;
                        if_id_enable  = 1'b1;
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                        mem_wb_enable = 1'b1;
                        if (branch_taken_ex) begin
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (load_use) begin
                            pc_enable    = 1'b0;
                            if_id_enable = 1'b0;
                            id_ex_bubble = 1'b1;
                        end
                        if (halt_req) begin
                            state_d     = StDrain;
                            drain_cnt_d = 4'(DRAIN_CYCLES);
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StDrain: begin
                    if (mem_busy) begin
                        mem_wb_enable = 1'b1;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        id_ex_enable  = 1'b1;
                        id_ex_bubble  = 1'b1;
                        ex_mem_enable = 1'b1;
                        mem_wb_enable = 1'b1;
                        if (branch_taken_ex) begin
                            pc_enable   = 1'b1;
                            if_id_flush = 1'b1;
                        end
                        drain_cnt_d = drain_cnt_q - 4'd1;
                        if (drain_cnt_q == 4'd1) begin
                            state_d = StHalt;
                        end
                    end
                end
                StHalt: begin
                    halted = 1'b1;
                    if (!halt_req) begin
                        state_d = StRun;
                    end
                end
            endcase

            if (state_q != StHalt) begin
                if (!pc_enable && (stall_q != '1)) begin
                    stall_d = stall_q + STALL_CNT_W'(1);
                end
                if (if_id_flush && (flush_q != '1)) begin
                    flush_d = flush_q + FLUSH_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        drain_cnt_q <= drain_cnt_d;
        stall_q     <= stall_d;
        flush_q     <= flush_d;
    end

    assign state_out    = state_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush controller for the 4-register ARM pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates the per-stage enable and bubble/flush controls from three conditions: load-use hazards, taken branches resolved in EX, and data-memory wait.
- Provides a halt/drain sequence that retires in-flight instructions before freezing the core.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- DRAIN_CYCLES, 3, bubble cycles inserted after halt entry so in-flight instructions retire (1..15).
- STALL_CNT_W, 16, width of stall_cycles counter.
- FLUSH_CNT_W, 8, width of flush_count counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rn  in  4  ID-stage first source register
- id_rm  in  4  ID-stage second source register
- id_rn_used  in  1  id_rn is a real operand
- id_rm_used  in  1  id_rm is a real operand
- ex_rd  in  4  EX-stage destination register
- ex_mem_read  in  1  EX-stage instruction is a load
- branch_taken_ex  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; MEM stage must hold
- halt_req  in  1  level request to halt the core
- pc_enable  out  1  PC register update
- if_id_enable  out  1  IF/ID load
- if_id_flush  out  1  IF/ID clears to NOP on next edge
- id_ex_enable  out  1  ID/EX load
- id_ex_bubble  out  1  ID/EX loads NOP controls
- ex_mem_enable  out  1  EX/MEM load
- mem_wb_enable  out  1  MEM/WB load
- mem_wb_bubble  out  1  MEM/WB loads zero controls (reg_write_enable=0, mem_to_reg_select=0)
- state_out  out  2  RUN=0, MEM_WAIT=1, DRAIN=2, HALT=3
- halted  out  1  state==HALT
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_enable=0 in RUN/MEM_WAIT/DRAIN
- flush_count  out  FLUSH_CNT_W  saturating count of cycles with if_id_flush=1

Behaviour:
- Reset (sampled on posedge):
  - state=RUN, drain counter=0, both counters=0.
  - While reset is high, the combinational outputs are: all enables 0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1, halted=0.
  - Reset mid-drain or mid-wait abandons the sequence; the next cycle is RUN.
- Outputs are combinational from state and inputs. The state register and counters update on posedge clk.
- load_use = ex_mem_read && ((id_rn_used && id_rn==ex_rd) || (id_rm_used && id_rm==ex_rd)).
- Default in RUN: every enable is 1; every flush/bubble is 0.
- RUN, priority order:
  - mem_busy: all enables 0 except mem_wb_enable=1, with mem_wb_bubble=1. This retires the WB instruction exactly once. Next state is MEM_WAIT.
  - branch_taken_ex: pc_enable=1 (loads target), if_id_flush=1, id_ex_bubble=1, all other enables 1. A simultaneous load_use is ignored because the ID instruction is squashed.
  - load_use: pc_enable=0, if_id_enable=0, id_ex_bubble=1. ex_mem_enable and mem_wb_enable stay 1. Exactly one bubble per hazard, since the load leaves EX on the next edge.
  - halt_req with mem_busy=0: this cycle behaves as RUN per the rules above. Next state is DRAIN, with the drain counter loaded to DRAIN_CYCLES.
- MEM_WAIT:
  - Outputs are the same as the RUN mem_busy case while mem_busy=1.
  - When mem_busy=0, the cycle is evaluated exactly as RUN, including the branch, load-use and halt rules. The state returns to RUN (or to DRAIN if halt_req).
  - branch_taken_ex stays held by the frozen EX/MEM register and is acted on in the release cycle.
- DRAIN:
  - pc_enable=0, if_id_enable=0, id_ex_bubble=1, ex_mem_enable=1, mem_wb_enable=1.
  - If mem_busy: freeze as in the MEM_WAIT outputs; the counter holds.
  - Otherwise the counter decrements. When it is 1 and decrementing, the next state is HALT.
  - If branch_taken_ex: pc_enable=1, if_id_flush=1 (the PC takes the target and the IF/ID stays flushed); the counter continues.
  - Deasserting halt_req does not abort DRAIN.
- HALT:
  - All enables 0, all flush/bubble 0, halted=1.
  - When halt_req=0, the next state is RUN, and fetch resumes from the held PC.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at all-ones; they never wrap.
  - No counting while reset is high or in HALT.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_rn_used=1 for 1 cycle -> pc_enable=0, if_id_enable=0, id_ex_bubble=1, ex_mem_enable=1 for exactly 1 cycle; stall_cycles 0->1. Repeat with id_rn_used=0 -> no stall.
- Branch: branch_taken_ex=1 together with a load_use match -> pc_enable=1, if_id_flush=1, id_ex_bubble=1; flush_count increments; stall_cycles unchanged.
- Memory wait: mem_busy=1 for 4 cycles -> state_out=1 from the 2nd cycle; all enables 0 except mem_wb_enable=1 with mem_wb_bubble=1; stall_cycles +=4. Release cycle with branch_taken_ex=1 -> flush applied, state_out=0.
- Halt: halt_req=1 in RUN, DRAIN_CYCLES=3 -> state_out 2 for 3 cycles with id_ex_bubble=1, then 3 with halted=1. Counters frozen in HALT. halt_req=0 -> RUN next cycle.
- Drain interactions: mem_busy=1 for 2 cycles mid-DRAIN -> DRAIN lasts 5 cycles total. Drop halt_req mid-drain -> still reaches HALT for 1 cycle, then RUN.
- Saturation and reset: force 70000 stall cycles -> stall_cycles=16'hFFFF held. Assert reset mid-DRAIN -> enables 0, flush/bubble outputs 1 during reset, then state_out=0 and counters 0.
